// File: rtl/pattern_osc_pkg.sv
// pattern_osc_pkg
// Shared definitions for the step-pattern tone generator.
//   mode_e : pattern register update mode (shift-in, rotate, hold, clear)
package pattern_osc_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_CLEAR  = 2'b11
  } mode_e;

endpackage

// File: rtl/tone_osc.sv
// tone_osc
// Square-wave oscillator with a programmable half-period of top+1 cycles.
// A top of zero mutes the output (held low, counter parked at zero).
// Ports:
//   clk  in  1        system clock (rising edge)
//   rst  in  1        synchronous active-high reset
//   top  in  PITCH_W  half-period limit
//   out  out 1        square-wave output, straight from a flop
module tone_osc #(
  parameter int PITCH_W = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PITCH_W-1:0] top,
  output logic               out
);

  logic [PITCH_W-1:0] r_count;
  logic               r_out;

  // The >= compare (rather than ==) makes a limit that drops below the
  // running count restart immediately instead of wrapping the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_out   <= 1'b0;
    end else if (top == '0) begin
      r_count <= '0;
      r_out   <= 1'b0;
    end else if (r_count >= top) begin
      r_count <= '0;
      r_out   <= ~r_out;
    end else begin
      r_count <= r_count + PITCH_W'(1);
    end
  end

  assign out = r_out;

endmodule

// File: rtl/pattern_osc.sv
// pattern_osc
// Step-pattern tone generator. A tick divider steps a STEPS-bit pattern
// register (shift-in / rotate / hold / clear); the pattern shifted left by
// SHIFT is registered as the half-period limit of a tone oscillator.
// Ports:
//   clk      in  1      system clock (rising edge)
//   rst      in  1      synchronous active-high reset
//   din      in  1      serial pattern bit, active-high
//   mode     in  2      00 shift, 01 rotate, 10 hold, 11 clear
//   pattern  out STEPS  current pattern register
//   tick     out 1      one-cycle pulse marking a pattern step
//   osc_out  out 1      square-wave tone
module pattern_osc
  import pattern_osc_pkg::*;
#(
  parameter int STEPS    = 6,
  parameter int SHIFT    = 9,
  parameter int PITCH_W  = 17,
  parameter int TICK_DIV = 1 << 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic [1:0]       mode,
  output logic [STEPS-1:0] pattern,
  output logic             tick,
  output logic             osc_out
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  if (STEPS + SHIFT > PITCH_W) begin : g_bad_width
    $error("pattern_osc: STEPS+SHIFT exceeds PITCH_W");
  end
  if (STEPS < 1) begin : g_bad_steps
    $error("pattern_osc: STEPS must be at least 1");
  end
  if (TICK_DIV < 2) begin : g_bad_div
    $error("pattern_osc: TICK_DIV must be at least 2");
  end

  logic [DIV_W-1:0]   r_div_count;
  logic [DIV_W-1:0]   w_div_next;
  logic               r_tick;
  logic [STEPS-1:0]   r_pattern;
  logic [STEPS-1:0]   w_pattern_next;
  logic [STEPS-1:0]   w_shift_val;
  logic [STEPS-1:0]   w_rot_val;
  logic [PITCH_W-1:0] r_top;
  mode_e              w_mode;

  // Divider: tick is registered from the next count value so that it is
  // high in exactly the cycle where the count sits at TICK_DIV-1.
  assign w_div_next = (r_div_count == DIV_LAST) ? '0 : r_div_count + DIV_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_count <= '0;
      r_tick      <= 1'b0;
    end else begin
      r_div_count <= w_div_next;
      r_tick      <= (w_div_next == DIV_LAST);
    end
  end

  // A single-bit pattern has no bits to move: shift just loads din and
  // rotate leaves the bit in place.
  if (STEPS == 1) begin : g_one_step
    assign w_shift_val = din;
    assign w_rot_val   = r_pattern;
  end else begin : g_multi_step
    assign w_shift_val = {din, r_pattern[STEPS-1:1]};
    assign w_rot_val   = {r_pattern[0], r_pattern[STEPS-1:1]};
  end

  assign w_mode = mode_e'(mode);

  always_comb begin
    w_pattern_next = r_pattern;
    unique case (w_mode)
      MODE_SHIFT:  w_pattern_next = w_shift_val;
      MODE_ROTATE: w_pattern_next = w_rot_val;
      MODE_HOLD:   w_pattern_next = r_pattern;
      MODE_CLEAR:  w_pattern_next = '0;
      default:     w_pattern_next = r_pattern;
    endcase
  end

  // din/mode only matter on the edge that closes a tick-high cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern <= '0;
    end else if (r_tick) begin
      r_pattern <= w_pattern_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_top <= '0;
    end else begin
      r_top <= PITCH_W'(r_pattern) << SHIFT;
    end
  end

  tone_osc #(
    .PITCH_W (PITCH_W)
  ) u_tone_osc (
    .clk (clk),
    .rst (rst),
    .top (r_top),
    .out (osc_out)
  );

  assign pattern = r_pattern;
  assign tick    = r_tick;

endmodule

// File: doc/pattern_osc.md
# pattern_osc

Parametrised step-pattern tone generator for the logic-noise audio path. An internal tick divider clocks a STEPS-bit pattern register that has four modes: shift-in, rotate, hold and clear. The pattern, scaled by a fixed left shift, sets the half-period of a square-wave tone oscillator. The block sits between the button/LED front end and the PWM audio pin, and replaces the free-running-counter-bit clock and fixed-width pattern of the previous generation.

## Interface
Parameters:
- STEPS, 6, pattern register width (≥1)
- SHIFT, 9, left shift applied to pattern to form the half-period limit
- PITCH_W, 17, oscillator counter width; elaboration error if STEPS+SHIFT > PITCH_W
- TICK_DIV, 1<<20, clk cycles per pattern step (≥2)

Ports:
- clk  in  1  system clock; everything is on its rising edge
- rst  in  1  synchronous, active-high reset
- din  in  1  serial pattern bit, active-high (caller inverts active-low buttons)
- mode  in  2  pattern mode: 00 SHIFT, 01 ROTATE, 10 HOLD, 11 CLEAR
- pattern  out  STEPS  current pattern register (drives LEDs)
- tick  out  1  one-cycle pulse marking a pattern step
- osc_out  out  1  square-wave tone

## Operation
- Reset values: divider count 0, tick 0, pattern 0, limit register 0, osc count 0, osc_out 0.
- Divider:
  - Counts 0..TICK_DIV-1 and then wraps to 0.
  - tick is a registered signal, high for exactly the one cycle in which count == TICK_DIV-1.
  - tick period is exactly TICK_DIV cycles.
- Pattern update: happens only on the clk edge that ends a tick-high cycle. din and mode are sampled on that edge only; changes between ticks are ignored.
  - SHIFT: pattern ← {din, pattern[STEPS-1:1]}, so new bits enter at the MSB and move toward the LSB.
  - ROTATE: pattern ← {pattern[0], pattern[STEPS-1:1]}.
  - HOLD: pattern unchanged.
  - CLEAR: pattern ← 0.
  - STEPS=1: SHIFT loads din; ROTATE is equivalent to HOLD.
- Limit register:
  - Registered every cycle: top ← zero-extend(pattern << SHIFT) to PITCH_W.
  - Bits above STEPS+SHIFT are always 0.
- Tone oscillator (sub-module tone_osc), per cycle:
  - If top == 0: count ← 0, osc_out ← 0. This is mute.
  - Else if count ≥ top: count ← 0, osc_out toggles.
  - Else: count ← count+1.
  - Half-period is top+1 cycles; full period is 2·(top+1) cycles.
- Limit decrease: if top falls below the current count, the ≥ compare causes a toggle and a restart on the next cycle. The counter never runs through the full PITCH_W range.
- Limit increase: the current half-period stretches to the new top with no glitch.
- Reset mid-operation: all state returns to its reset values on the next edge, and the divider phase restarts from 0.

## Timing
- Tick high in cycle N → pattern new in cycle N+1 → top new in N+2 → oscillator compares against new top in N+2.
- din/mode → pattern latency: up to TICK_DIV cycles, depending on the divider phase.
- First tick after rst deasserts: high in cycle TICK_DIV-1, counting the first post-reset cycle as cycle 0.
- No combinational path from any input to any output; all outputs come straight from flops.

## Structure
- Shared package pattern_osc_pkg:
  - mode encodings MODE_SHIFT=2'b00, MODE_ROTATE=2'b01, MODE_HOLD=2'b10, MODE_CLEAR=2'b11;
  - mode typedef.
- Sub-module tone_osc:
  - parameter PITCH_W;
  - ports clk, rst, top[PITCH_W-1:0], out;
  - reusable by later multi-voice blocks.
- Divider and pattern register live in the top-level pattern_osc.

## Test plan
Bench parameters: STEPS=6, SHIFT=0, PITCH_W=8, TICK_DIV=4.
- Reset: assert rst 3 cycles → pattern=0, tick=0, osc_out=0; first tick appears 3 cycles after deassertion, then every 4 cycles.
- Shift: mode=00, din=1 for 3 ticks then din=0 for 1 tick → pattern 100000, 110000, 111000, then 011100.
- Rotate/hold/clear:
  - pattern=000001, mode=01 → 100000 next step, then 010000.
  - mode=10 → unchanged for 5 ticks.
  - mode=11 → 000000 on the next tick.
  - din and mode toggled between ticks have no effect.
- Tone period: pattern=000011 held (top=3) → osc_out toggles every 4 cycles, period 8.
- Mute and resume: pattern=000000 → osc_out stays 0. Then pattern=000001 → first toggle 2 cycles after top updates.
- Limit drop and mid-run reset:
  - top=40 with count=30, pattern changed so that top=5 → toggle and count=0 on the next compare cycle, no long half-period.
  - rst asserted mid-count → all outputs 0 on the following cycle.
